// File: rtl/mem_responder.sv
// Single-port memory responder: queues core requests in a small FIFO and
// serves them in order through a fixed-latency access FSM.
// Ports: clk, reset (sync, active-high), mem_req (in), mem_rsp (out),
//        fifo_full, overflow_err (sticky), busy.
package mem_pkg;
  localparam int NUM_OF_CORES = 4;

  typedef struct packed {
    logic        vld;
    logic [3:0]  core_id;
    logic        req_type;
    logic [15:0] addr;
    logic [31:0] data;
  } request_t;
endpackage

module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  request_t mem_req,
  output request_t mem_rsp,
  output logic     fifo_full,
  output logic     overflow_err,
  output logic     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  request_t          fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [31:0]       mem [2**ADDR_W];

  state_t            state;
  state_t            state_n;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  lat_n;
  request_t          work;
  request_t          work_n;
  request_t          rsp_n;

  logic              pop;
  logic              push;
  logic              drop;
  logic              mem_we;
  logic [ADDR_W-1:0] idx;

  // Only the low word-index bits select the array word.
  assign idx       = work.addr[ADDR_W-1:0];
  assign fifo_full = (count == CNT_W'(DEPTH));
  assign busy      = (state != IDLE) || (count != '0);

  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = mem_req.vld && (!fifo_full || pop);
  assign drop = mem_req.vld && fifo_full && !pop;

  always_comb begin
    state_n = state;
    lat_n   = lat_cnt;
    work_n  = work;
    rsp_n   = mem_rsp;
    pop     = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          work_n  = fifo_q[rd_ptr];
          lat_n   = LAT_W'(LATENCY - 1);
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt != '0) begin
          lat_n = lat_cnt - 1'b1;
        end else begin
          // Read uses the pre-edge array; writes echo their data.
          mem_we    = work.req_type;
          rsp_n     = work;
          rsp_n.vld = 1'b1;
          if (!work.req_type) rsp_n.data = mem[idx];
          state_n   = RESP;
        end
      end
      RESP: begin
        rsp_n.vld = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      work         <= '0;
      mem_rsp      <= '0;
      overflow_err <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state        <= state_n;
      lat_cnt      <= lat_n;
      work         <= work_n;
      mem_rsp      <= rsp_n;
      overflow_err <= overflow_err | drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr] <= mem_req;
  end

  // Array is never reset; completed writes survive.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[idx] <= work.data;
  end

endmodule
